// File: rtl/hwpe_ctrl_regfile_bist_if.sv
// Test-port bundle between the BIST engine and the register-file test wrapper
// (BIST select, CSN_T, WEN_T, A_T, D_T, BE_T toward the wrapper; Q_T back).
interface hwpe_ctrl_regfile_bist_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    bist;
  logic                    csn;
  logic                    wen;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output bist, csn, wen, addr, wdata, be, input rdata);
  modport slave  (input bist, csn, wen, addr, wdata, be, output rdata);
endinterface

// File: rtl/hwpe_ctrl_regfile_bist.sv
// March C- BIST engine for the HWPE control register file: one access per cycle, reads wait
// READ_LATENCY cycles before comparing; reports sticky pass/fail, first-failure diagnostics and a saturating error count.
module hwpe_ctrl_regfile_bist #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] BACKGROUND = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  hwpe_ctrl_regfile_bist_if.master mem,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [ADDR_WIDTH-1:0]   fail_addr_o,
  output logic [2:0]              fail_elem_o,
  output logic [7:0]              err_cnt_o
);
  localparam int unsigned NUM_BYTE = DATA_WIDTH/8;
  localparam logic [ADDR_WIDTH-1:0] A_MAX = '1;
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_OP, S_WAIT, S_DONE} state_e;

  state_e                r_state;
  logic [2:0]            r_elem;
  logic                  r_ph;
  logic [1:0]            r_wcnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fail;
  logic                  r_csn;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NUM_BYTE-1:0]   r_be;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [2:0]            r_fail_elem;
  logic [7:0]            r_err_cnt;

  logic                  w_desc;
  logic                  w_two;
  logic                  w_addr_end;
  logic [2:0]            w_nxt_elem;
  logic [ADDR_WIDTH-1:0] w_nxt_addr;
  logic                  w_nxt_ph;
  logic                  w_last;
  logic                  w_nxt_rd;
  logic [DATA_WIDTH-1:0] w_nxt_wdat;
  logic [DATA_WIDTH-1:0] w_exp;
  logic                  w_mis;

  // Next-operation walker: E1..E4 are read-then-write on one address (r_ph selects the half).
  always_comb begin
    w_desc     = (r_elem >= 3'd3);
    w_two      = (r_elem != 3'd0) && (r_elem != 3'd5);
    w_addr_end = w_desc ? (r_addr == '0) : (r_addr == A_MAX);
    w_nxt_elem = r_elem;
    w_nxt_addr = r_addr;
    w_nxt_ph   = 1'b0;
    w_last     = 1'b0;
    if (w_two && !r_ph) begin
      w_nxt_ph = 1'b1;
    end else if (!w_addr_end) begin
      w_nxt_addr = w_desc ? r_addr - 1'b1 : r_addr + 1'b1;
    end else if (r_elem == 3'd5) begin
      w_last = 1'b1;
    end else begin
      w_nxt_elem = r_elem + 3'd1;
      w_nxt_addr = (r_elem >= 3'd2) ? A_MAX : '0;
    end
    w_nxt_rd   = (w_nxt_elem != 3'd0) && !w_nxt_ph;
    w_nxt_wdat = w_nxt_elem[0] ? ~BACKGROUND : BACKGROUND;
    w_exp      = r_elem[0] ? BACKGROUND : ~BACKGROUND;
    w_mis      = (mem.rdata != w_exp);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_elem      <= 3'd0;
      r_ph        <= 1'b0;
      r_wcnt      <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_csn       <= 1'b1;
      r_wen       <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
      r_err_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_state     <= S_OP;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
            r_err_cnt   <= 8'd0;
            r_elem      <= 3'd0;
            r_ph        <= 1'b0;
            r_addr      <= '0;
            r_csn       <= 1'b0;
            r_wen       <= 1'b0;
            r_wdata     <= BACKGROUND;
            r_be        <= '1;
          end
        end
        default: begin
          if (r_state == S_OP && r_wen) begin
            r_state <= S_WAIT;
            r_wcnt  <= WAIT_INIT;
            r_csn   <= 1'b1;
            r_be    <= '0;
            r_wdata <= '0;
          end else if (r_state == S_WAIT && r_wcnt != 2'd0) begin
            r_wcnt <= r_wcnt - 2'd1;
          end else begin
            // Last WAIT cycle: Q_T now carries the word read in the OP cycle.
            if (r_state == S_WAIT && w_mis) begin
              if (!r_fail) begin
                r_fail_addr <= r_addr;
                r_fail_elem <= r_elem;
              end
              r_fail <= 1'b1;
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_csn   <= 1'b1;
              r_wen   <= 1'b1;
              r_be    <= '0;
              r_wdata <= '0;
            end else begin
              r_state <= S_OP;
              r_elem  <= w_nxt_elem;
              r_addr  <= w_nxt_addr;
              r_ph    <= w_nxt_ph;
              r_csn   <= 1'b0;
              r_wen   <= w_nxt_rd;
              r_wdata <= w_nxt_rd ? '0 : w_nxt_wdat;
              r_be    <= '1;
            end
          end
        end
      endcase
    end
  end

  assign mem.bist   = r_busy;
  assign mem.csn    = r_csn;
  assign mem.wen    = r_wen;
  assign mem.addr   = r_addr;
  assign mem.wdata  = r_wdata;
  assign mem.be     = r_be;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign fail_o      = r_fail;
  assign fail_addr_o = r_fail_addr;
  assign fail_elem_o = r_fail_elem;
  assign err_cnt_o   = r_err_cnt;
endmodule
